// File: rtl/mem_2p_pkg.sv
// Shared types and constants for the two-port memory access controller.
package mem_2p_pkg;

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_LS     = 3'd1,
        ST_WAKE   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DS     = 3'd4,
        ST_SD     = 3'd5
    } mem_2p_state_e;

    localparam logic [1:0] PWR_NORMAL = 2'b00;
    localparam logic [1:0] PWR_DS     = 2'b01;
    localparam logic [1:0] PWR_SD     = 2'b10;

    // Write-mask value that leaves every memory bit untouched, for widths up to 64.
    function automatic logic [63:0] ones_mask(input int unsigned w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/mem_2p_access_ctrl_if.sv
// Request/response streams between datapath logic and the memory access controller.
interface mem_2p_access_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    // Each stream transfers on a rising edge where vld & rdy are both high; a source
    // holds vld and its payload steady until that edge, and rdy may depend on vld.
    logic          wr_vld;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_mask;

    logic          rd_vld;
    logic          rd_rdy;
    logic [AW-1:0] rd_addr;

    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;

    modport master (
        output wr_vld, wr_addr, wr_data, wr_mask, rd_vld, rd_addr, rsp_rdy,
        input  wr_rdy, rd_rdy, rsp_vld, rsp_data
    );

    modport slave (
        input  wr_vld, wr_addr, wr_data, wr_mask, rd_vld, rd_addr, rsp_rdy,
        output wr_rdy, rd_rdy, rsp_vld, rsp_data
    );

endinterface

// File: rtl/mem_2p_rsp_fifo.sv
// Two-entry FIFO holding read data returned by the memory until the consumer takes it.
module mem_2p_rsp_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] slots [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Overflow and underflow requests are dropped rather than corrupting the pointers.
    assign push_ok = push && (count != 2'd2);
    assign pop_ok  = pop && (count != 2'd0);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            slots[0] <= '0;
            slots[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push_ok) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop_ok) rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_2p_access_ctrl.sv
// Drives a calypto_mem_2p: port-A writes, port-B reads with buffered responses,
// same-address conflict avoidance and light-sleep / deep-sleep / shutdown sequencing.
module mem_2p_access_ctrl
    import mem_2p_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int IDLE_LS = 8
) (
    input  logic                 clk,
    input  logic                 arst_n,
    mem_2p_access_ctrl_if.slave  bus,
    input  logic [1:0]           pwr_req,
    output logic                 pwr_ack,
    output logic                 mea,
    output logic                 rwa,
    output logic [AW-1:0]        wadra,
    output logic [AW-1:0]        radra,
    output logic [DW-1:0]        da,
    output logic [DW-1:0]        wma,
    output logic                 meb,
    output logic                 rwb,
    output logic [AW-1:0]        wadrb,
    output logic [AW-1:0]        radrb,
    output logic [DW-1:0]        db,
    output logic [DW-1:0]        wmb,
    input  logic [DW-1:0]        qb,
    output logic                 ls,
    output logic                 ds,
    output logic                 sd,
    output mem_2p_state_e        state_dbg
);

    localparam logic [63:0]   ONES_64   = ones_mask(DW);
    localparam logic [DW-1:0] MASK_ONES = ONES_64[DW-1:0];
    localparam int            IW        = (IDLE_LS > 1) ? $clog2(IDLE_LS) : 1;
    localparam logic [IW-1:0] IDLE_LIM  = IW'((IDLE_LS > 0) ? IDLE_LS - 1 : 0);

    mem_2p_state_e state;
    logic [IW-1:0] idle_cnt;
    logic          inflight;
    logic [1:0]    fifo_count;
    logic [2:0]    credit;
    logic          active;
    logic          any_vld;
    logic          pwr_off;
    logic          rd_fire;
    logic          wr_fire;
    logic          conflict;
    mem_2p_state_e pwr_dest;

    assign active   = (state == ST_ACTIVE);
    assign any_vld  = bus.wr_vld | bus.rd_vld;
    assign pwr_off  = (pwr_req != PWR_NORMAL);
    assign pwr_dest = (pwr_req == PWR_DS) ? ST_DS : ST_SD;
    assign credit   = {1'b0, fifo_count} + {2'b00, inflight};

    assign bus.rd_rdy = active && (credit < 3'd2);
    assign rd_fire    = bus.rd_vld & bus.rd_rdy;

    // A masked write to the address being read this cycle is held off one cycle,
    // so the read sees old data and the memory never sees the collision.
    assign conflict   = rd_fire && bus.wr_vld && (bus.wr_addr == bus.rd_addr)
                        && (bus.wr_mask != MASK_ONES);
    assign bus.wr_rdy = active && !conflict;
    assign wr_fire    = bus.wr_vld & bus.wr_rdy;

    assign mea   = wr_fire;
    assign rwa   = wr_fire;
    assign wadra = bus.wr_addr;
    assign radra = '0;
    assign da    = bus.wr_data;
    assign wma   = bus.wr_mask;

    assign meb   = rd_fire;
    assign rwb   = 1'b0;
    assign wadrb = '0;
    assign radrb = bus.rd_addr;
    assign db    = '0;
    assign wmb   = MASK_ONES;

    assign bus.rsp_vld = (fifo_count != 2'd0);
    assign state_dbg   = state;

    mem_2p_rsp_fifo #(.DW(DW)) u_rsp_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (inflight),
        .push_data (qb),
        .pop       (bus.rsp_vld & bus.rsp_rdy),
        .head      (bus.rsp_data),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= ST_ACTIVE;
            idle_cnt <= '0;
            inflight <= 1'b0;
            ls       <= 1'b0;
            ds       <= 1'b0;
            sd       <= 1'b0;
            pwr_ack  <= 1'b0;
        end else begin
            inflight <= rd_fire;
            case (state)
                ST_ACTIVE: begin
                    if (pwr_off) begin
                        state    <= ST_DRAIN;
                        idle_cnt <= '0;
                    end else if (any_vld) begin
                        idle_cnt <= '0;
                    end else if (IDLE_LS != 0) begin
                        if (idle_cnt == IDLE_LIM) begin
                            state    <= ST_LS;
                            ls       <= 1'b1;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                ST_LS: begin
                    if (pwr_off) begin
                        state <= ST_DRAIN;
                        ls    <= 1'b0;
                    end else if (any_vld) begin
                        state <= ST_WAKE;
                        ls    <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    state <= pwr_off ? ST_DRAIN : ST_ACTIVE;
                end
                // The last accepted read must land in the response buffer before sleeping.
                ST_DRAIN: begin
                    if (!pwr_off) begin
                        state <= ST_WAKE;
                    end else if (!inflight) begin
                        state   <= pwr_dest;
                        ds      <= (pwr_req == PWR_DS);
                        sd      <= (pwr_req != PWR_DS);
                        pwr_ack <= 1'b1;
                    end
                end
                ST_DS, ST_SD: begin
                    if (!pwr_off) begin
                        state   <= ST_WAKE;
                        ds      <= 1'b0;
                        sd      <= 1'b0;
                        pwr_ack <= 1'b0;
                    end else begin
                        state <= pwr_dest;
                        ds    <= (pwr_req == PWR_DS);
                        sd    <= (pwr_req != PWR_DS);
                    end
                end
                default: begin
                    state   <= ST_ACTIVE;
                    ls      <= 1'b0;
                    ds      <= 1'b0;
                    sd      <= 1'b0;
                    pwr_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule
